softusb_txgen: RTL and testbench

Parametrised next-generation USB NRZI line transmitter for the softusb core. It serialises bytes from the softusb microcontroller side, applies bit stuffing and NRZI encoding, and drives the transceiver txp/txm/txoe pins.
- Compared with the existing transmitter, it adds:
  - automatic SYNC insertion;
  - an explicit last-byte marker instead of inferring end of packet from tx_valid falling;
  - underrun detection;
  - a parametrised EOP length;
  - parametrised bit-rate dividers.
- It sits between the softusb I/O registers and the pad drivers, in the usb_clk domain.

---
 rtl/softusb_pkg.sv | 26 ++
 rtl/softusb_txgen_if.sv | 25 ++
 rtl/softusb_txgen_stuffer.sv | 78 +++++++
 rtl/softusb_txgen.sv | 196 +++++++++++++++++++
 tb/tb_softusb_txgen.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/softusb_pkg.sv
// softusb_pkg: definitions shared by the softusb transmitter slice.
//   tx_state_e  - transmitter FSM states
//   SYNC_BYTE   - SYNC pattern, shifted LSB first
//   line_j/k    - {D+, D-} levels of the J and K line states for a given speed
package softusb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_SE0,
    ST_J
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Full speed idles with D+ high; low speed idles with D- high.
  function automatic logic [1:0] line_j(input logic ls);
    return {~ls, ls};
  endfunction

  function automatic logic [1:0] line_k(input logic ls);
    return {ls, ~ls};
  endfunction

endpackage

// File: rtl/softusb_txgen_if.sv
// softusb_txgen_if: byte-stream handshake between the softusb I/O registers
// and the line transmitter.
//   tx_data/tx_valid/tx_last - byte offered to the transmitter, LSB first
//   tx_ready                 - one-cycle pulse, byte consumed
//   tx_busy                  - packet or standalone EOP in progress
//   tx_underrun/underrun_clr - sticky underrun flag and its clear
interface softusb_txgen_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_underrun;
  logic       underrun_clr;

  modport master (
    output tx_data, tx_valid, tx_last, underrun_clr,
    input  tx_ready, tx_busy, tx_underrun
  );

  modport slave (
    input  tx_data, tx_valid, tx_last, underrun_clr,
    output tx_ready, tx_busy, tx_underrun
  );
endinterface

// File: rtl/softusb_txgen_stuffer.sv
// softusb_txgen_stuffer: byte shifter with USB bit stuffing.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - clear run counter and byte state (held while idle)
//   load       - load data/nostuff AND emit data[0] in the same strobe
//   next       - emit the next bit of the current byte (or a stuffed zero)
//   data       - byte to load; nostuff - shift this byte without stuffing
//   bit_out    - bit emitted by this load/next
//   done       - all bits and any pending stuffed zero have been emitted
module softusb_txgen_stuffer #(
  parameter int unsigned STUFF_RUN = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       next,
  input  logic [7:0] data,
  input  logic       nostuff,
  output logic       bit_out,
  output logic       done
);
  localparam int unsigned OW = $clog2(STUFF_RUN + 1);

  logic [7:0]    sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          nostuff_q, nostuff_d;
  logic          stuff;

  // A full run of ones forces a zero before anything else, including the
  // first bit of the following byte, so done stays low until it is sent.
  assign stuff = !nostuff_q && (ones_q == OW'(STUFF_RUN));
  assign done  = (cnt_q == '0) && !stuff;

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    nostuff_d = nostuff_q;
    bit_out   = 1'b1;
    if (load) begin
      bit_out   = data[0];
      sr_d      = {1'b0, data[7:1]};
      cnt_d     = 3'd7;
      nostuff_d = nostuff;
      ones_d    = (nostuff || !data[0]) ? '0 : ones_q + OW'(1);
    end else if (stuff) begin
      bit_out = 1'b0;
      if (next) ones_d = '0;
    end else begin
      bit_out = sr_q[0];
      if (next) begin
        sr_d   = {1'b0, sr_q[7:1]};
        cnt_d  = cnt_q - 3'd1;
        ones_d = (nostuff_q || !sr_q[0]) ? '0 : ones_q + OW'(1);
      end
    end
    if (clr && !load) begin
      cnt_d     = '0;
      ones_d    = '0;
      nostuff_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      ones_q    <= '0;
      nostuff_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      nostuff_q <= nostuff_d;
    end
  end
endmodule

// File: rtl/softusb_txgen.sv
// softusb_txgen: USB NRZI line transmitter (SYNC, bit stuffing, EOP).
//   usb_clk, usb_rst_n - clock, asynchronous active-low reset
//   tx                 - byte handshake, busy and underrun flags (slave side)
//   low_speed          - selects LS_DIV and low-speed J/K polarity
//   generate_eop       - pulse requesting a standalone keep-alive EOP
//   txp, txm, txoe     - registered pad drives
module softusb_txgen
  import softusb_pkg::*;
#(
  parameter int unsigned FS_DIV       = 6,
  parameter int unsigned LS_DIV       = 48,
  parameter int unsigned STUFF_RUN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned AUTO_SYNC    = 1
) (
  input  logic                  usb_clk,
  input  logic                  usb_rst_n,
  softusb_txgen_if.slave        tx,
  input  logic                  low_speed,
  input  logic                  generate_eop,
  output logic                  txp,
  output logic                  txm,
  output logic                  txoe
);
  localparam int unsigned    CW       = $clog2(LS_DIV);
  localparam logic [CW-1:0]  FS_M1    = CW'(FS_DIV - 1);
  localparam logic [CW-1:0]  LS_M1    = CW'(LS_DIV - 1);
  localparam logic [1:0]     SE0_LAST = 2'(EOP_SE0_BITS - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ls_q, ls_d;
  logic          gce;
  logic [1:0]    se0_cnt_q, se0_cnt_d;
  logic          lvl_q, lvl_d;      // NRZI level: 0 = J, 1 = K
  logic          last_q, last_d;
  logic          ka_q, ka_d;        // current EOP is the standalone keep-alive
  logic          pend_q, pend_d;
  logic          und_q, und_d, und_set;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          txp_q, txm_q, txoe_q, txoe_d;
  logic [1:0]    pins_d;

  logic          st_load, st_next, st_nostuff, st_bit, st_done;
  logic [7:0]    st_data;

  // Speed is latched at the wrap so a bit period is never cut short.
  assign gce   = (cnt_q == (ls_q ? LS_M1 : FS_M1));
  assign cnt_d = gce ? '0 : cnt_q + CW'(1);
  assign ls_d  = gce ? low_speed : ls_q;

  softusb_txgen_stuffer #(
    .STUFF_RUN (STUFF_RUN)
  ) u_stuffer (
    .clk     (usb_clk),
    .rst_n   (usb_rst_n),
    .clr     (state_q == ST_IDLE),
    .load    (st_load),
    .next    (st_next),
    .data    (st_data),
    .nostuff (st_nostuff),
    .bit_out (st_bit),
    .done    (st_done)
  );

  always_comb begin
    state_d    = state_q;
    se0_cnt_d  = se0_cnt_q;
    lvl_d      = lvl_q;
    last_d     = last_q;
    ka_d       = ka_q;
    pend_d     = pend_q | generate_eop;
    und_set    = 1'b0;
    ready_d    = 1'b0;
    st_load    = 1'b0;
    st_next    = 1'b0;
    st_data    = tx.tx_data;
    st_nostuff = 1'b0;

    if (gce) begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            state_d   = ST_SE0;
            se0_cnt_d = '0;
            ka_d      = 1'b1;
          end else if (tx.tx_valid) begin
            st_load = 1'b1;
            if (AUTO_SYNC != 0) begin
              state_d    = ST_SYNC;
              st_data    = SYNC_BYTE;
              st_nostuff = 1'b1;
            end else begin
              state_d = ST_DATA;
              ready_d = 1'b1;
              last_d  = tx.tx_last;
            end
          end
        end
        ST_SYNC, ST_DATA: begin
          if (!st_done) begin
            st_next = 1'b1;
          end else if (state_q == ST_DATA && last_q) begin
            state_d   = ST_SE0;
            se0_cnt_d = '0;
          end else if (tx.tx_valid) begin
            st_load = 1'b1;
            state_d = ST_DATA;
            ready_d = 1'b1;
            last_d  = tx.tx_last;
          end else begin
            und_set   = 1'b1;
            state_d   = ST_SE0;
            se0_cnt_d = '0;
          end
        end
        ST_SE0: begin
          if (se0_cnt_q == SE0_LAST) state_d = ST_J;
          else se0_cnt_d = se0_cnt_q + 2'd1;
        end
        ST_J: begin
          state_d = ST_IDLE;
          if (ka_q) begin
            ka_d   = 1'b0;
            pend_d = generate_eop;  // a request landing now is kept
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (st_load || st_next) lvl_d = st_bit ? lvl_q : ~lvl_q;
    if (state_d == ST_IDLE) lvl_d = 1'b0;

    // Pins follow the state being entered at each strobe; while idle the
    // J level tracks low_speed every cycle.
    pins_d = {txp_q, txm_q};
    txoe_d = txoe_q;
    if (gce || state_q == ST_IDLE) begin
      case (state_d)
        ST_IDLE: begin pins_d = line_j(low_speed); txoe_d = 1'b0; end
        ST_SE0:  begin pins_d = 2'b00;             txoe_d = 1'b1; end
        ST_J:    begin pins_d = line_j(ls_q);      txoe_d = 1'b1; end
        default: begin
          pins_d = lvl_d ? line_k(ls_q) : line_j(ls_q);
          txoe_d = 1'b1;
        end
      endcase
    end

    und_d  = und_set ? 1'b1 : (tx.underrun_clr ? 1'b0 : und_q);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ls_q      <= 1'b0;
      se0_cnt_q <= '0;
      lvl_q     <= 1'b0;
      last_q    <= 1'b0;
      ka_q      <= 1'b0;
      pend_q    <= 1'b0;
      und_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      txp_q     <= 1'b1;
      txm_q     <= 1'b0;
      txoe_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ls_q      <= ls_d;
      se0_cnt_q <= se0_cnt_d;
      lvl_q     <= lvl_d;
      last_q    <= last_d;
      ka_q      <= ka_d;
      pend_q    <= pend_d;
      und_q     <= und_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      txp_q     <= pins_d[1];
      txm_q     <= pins_d[0];
      txoe_q    <= txoe_d;
    end
  end

  assign tx.tx_ready    = ready_q;
  assign tx.tx_busy     = busy_q;
  assign tx.tx_underrun = und_q;
  assign txp            = txp_q;
  assign txm            = txm_q;
  assign txoe           = txoe_q;
endmodule

// File: tb/tb_softusb_txgen.sv
// tb_softusb_txgen: directed bench for softusb_txgen. Expected pin sequences
// are written as J/K/0 strings (0 = SE0), one character per bit time.
module tb_softusb_txgen;
  logic usb_clk = 1'b0;
  logic usb_rst_n;
  logic low_speed;
  logic generate_eop;
  logic txp, txm, txoe;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_cnt = 0;
  int   rdy_base;

  softusb_txgen_if tx_if ();

  softusb_txgen #(
    .FS_DIV       (6),
    .LS_DIV       (48),
    .STUFF_RUN    (6),
    .EOP_SE0_BITS (2),
    .AUTO_SYNC    (1)
  ) dut (
    .usb_clk      (usb_clk),
    .usb_rst_n    (usb_rst_n),
    .tx           (tx_if.slave),
    .low_speed    (low_speed),
    .generate_eop (generate_eop),
    .txp          (txp),
    .txm          (txm),
    .txoe         (txoe)
  );

  always #5 usb_clk = ~usb_clk;

  always @(negedge usb_clk) if (tx_if.tx_ready === 1'b1) rdy_cnt <= rdy_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int unsigned k = 0;
    while (tx_if.tx_ready !== 1'b1 && k < 2000) begin
      @(negedge usb_clk);
      k++;
    end
    chk(tag, 32'(tx_if.tx_ready), 32'd1);
    @(negedge usb_clk);
  endtask

  task automatic check_seq(input string tag, input string seq, input int unsigned div, input logic ls);
    int unsigned k = 0;
    logic [2:0] exp;
    byte ch;
    while (txoe !== 1'b1 && k < 400) begin
      @(negedge usb_clk);
      k++;
    end
    chk({tag, "_start"}, 32'(txoe), 32'd1);
    for (int unsigned i = 0; i < seq.len(); i++) begin
      ch = seq[i];
      if (ch == "J")      exp = {1'b1, ~ls, ls};
      else if (ch == "K") exp = {1'b1, ls, ~ls};
      else                exp = 3'b100;
      for (int unsigned c = 0; c < div; c++) begin
        chk($sformatf("%s_bit%0d_cyc%0d", tag, i, c), 32'({txoe, txp, txm}), 32'(exp));
        chk($sformatf("%s_busy%0d_cyc%0d", tag, i, c), 32'(tx_if.tx_busy), 32'd1);
        @(negedge usb_clk);
      end
    end
    chk({tag, "_idle"}, 32'({txoe, txp, txm}), 32'({1'b0, ~ls, ls}));
    chk({tag, "_busy_end"}, 32'(tx_if.tx_busy), 32'd0);
  endtask

  initial begin
    usb_rst_n          = 1'b0;
    low_speed          = 1'b0;
    generate_eop       = 1'b0;
    tx_if.tx_data      = 8'h00;
    tx_if.tx_valid     = 1'b0;
    tx_if.tx_last      = 1'b0;
    tx_if.underrun_clr = 1'b0;
    repeat (3) @(negedge usb_clk);
    chk("rst_pins", 32'({txoe, txp, txm}), 32'(3'b010));
    chk("rst_ready", 32'(tx_if.tx_ready), 32'd0);
    chk("rst_busy", 32'(tx_if.tx_busy), 32'd0);
    chk("rst_underrun", 32'(tx_if.tx_underrun), 32'd0);
    usb_rst_n = 1'b1;
    repeat (10) @(negedge usb_clk);
    chk("idle_fs", 32'({txoe, txp, txm}), 32'(3'b010));

    // 1: SYNC + C3 + A5(last)
    rdy_base = rdy_cnt;
    fork
      begin
        tx_if.tx_data = 8'hC3; tx_if.tx_last = 1'b0; tx_if.tx_valid = 1'b1;
        wait_ready("t1_ready0");
        tx_if.tx_data = 8'hA5; tx_if.tx_last = 1'b1;
        wait_ready("t1_ready1");
        tx_if.tx_valid = 1'b0; tx_if.tx_last = 1'b0;
      end
      check_seq("t1", "KJKJKJKKKKJKJKKKKJJKJJKK00J", 6, 1'b0);
    join
    chk("t1_ready_count", 32'(rdy_cnt - rdy_base), 32'd2);
    chk("t1_underrun", 32'(tx_if.tx_underrun), 32'd0);

    // 2: FF FF(last) with stuffing across the byte boundary
    repeat (20) @(negedge usb_clk);
    rdy_base = rdy_cnt;
    fork
      begin
        tx_if.tx_data = 8'hFF; tx_if.tx_last = 1'b0; tx_if.tx_valid = 1'b1;
        wait_ready("t2_ready0");
        tx_if.tx_last = 1'b1;
        wait_ready("t2_ready1");
        tx_if.tx_valid = 1'b0; tx_if.tx_last = 1'b0;
      end
      check_seq("t2", "KJKJKJKKKKKKKKJJJJJJJKKKKK00J", 6, 1'b0);
    join
    chk("t2_ready_count", 32'(rdy_cnt - rdy_base), 32'd2);

    // 3: underrun after first byte, then clear
    repeat (20) @(negedge usb_clk);
    fork
      begin
        tx_if.tx_data = 8'h0F; tx_if.tx_last = 1'b0; tx_if.tx_valid = 1'b1;
        wait_ready("t3_ready0");
        tx_if.tx_valid = 1'b0;
      end
      check_seq("t3", "KJKJKJKKKKKKJKJK00J", 6, 1'b0);
    join
    repeat (5) @(negedge usb_clk);
    chk("t3_underrun_sticky", 32'(tx_if.tx_underrun), 32'd1);
    tx_if.underrun_clr = 1'b1;
    @(negedge usb_clk);
    tx_if.underrun_clr = 1'b0;
    chk("t3_underrun_clr", 32'(tx_if.tx_underrun), 32'd0);

    // 4: low-speed keep-alive EOP
    low_speed = 1'b1;
    repeat (100) @(negedge usb_clk);
    chk("t4_idle_ls", 32'({txoe, txp, txm}), 32'(3'b001));
    rdy_base = rdy_cnt;
    generate_eop = 1'b1;
    @(negedge usb_clk);
    generate_eop = 1'b0;
    check_seq("t4", "00J", 48, 1'b1);
    chk("t4_no_ready", 32'(rdy_cnt - rdy_base), 32'd0);

    // 5: keep-alive requested mid-packet follows the packet
    low_speed = 1'b0;
    repeat (100) @(negedge usb_clk);
    rdy_base = rdy_cnt;
    fork
      begin
        tx_if.tx_data = 8'hC3; tx_if.tx_last = 1'b1; tx_if.tx_valid = 1'b1;
        wait_ready("t5_ready0");
        tx_if.tx_valid = 1'b0; tx_if.tx_last = 1'b0;
        generate_eop = 1'b1;
        @(negedge usb_clk);
        generate_eop = 1'b0;
      end
      check_seq("t5_pkt", "KJKJKJKKKKJKJKKK00J", 6, 1'b0);
    join
    check_seq("t5_ka", "00J", 6, 1'b0);
    chk("t5_ready_count", 32'(rdy_cnt - rdy_base), 32'd1);

    // 6: reset mid-DATA, then a clean packet
    repeat (20) @(negedge usb_clk);
    tx_if.tx_data = 8'hFF; tx_if.tx_last = 1'b1; tx_if.tx_valid = 1'b1;
    wait_ready("t6_ready0");
    tx_if.tx_valid = 1'b0; tx_if.tx_last = 1'b0;
    repeat (12) @(negedge usb_clk);
    chk("t6_active", 32'(txoe), 32'd1);
    usb_rst_n = 1'b0;
    #1;
    chk("t6_rst_pins", 32'({txoe, txp, txm}), 32'(3'b010));
    chk("t6_rst_busy", 32'(tx_if.tx_busy), 32'd0);
    low_speed = 1'b1;
    repeat (3) @(negedge usb_clk);
    usb_rst_n = 1'b1;
    repeat (3) @(negedge usb_clk);
    chk("t6_idle_ls", 32'({txoe, txp, txm}), 32'(3'b001));
    low_speed = 1'b0;
    repeat (100) @(negedge usb_clk);
    chk("t6_idle_fs", 32'({txoe, txp, txm}), 32'(3'b010));
    fork
      begin
        tx_if.tx_data = 8'hA5; tx_if.tx_last = 1'b1; tx_if.tx_valid = 1'b1;
        wait_ready("t6_ready1");
        tx_if.tx_valid = 1'b0; tx_if.tx_last = 1'b0;
      end
      check_seq("t6", "KJKJKJKKKJJKJJKK00J", 6, 1'b0);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
